// File: rtl/wb_arb_pkg.sv
// Shared state type, index-width helper and round-robin pick function for wb_rr_arbiter.
package wb_arb_pkg;

    localparam int unsigned MAX_MASTERS = 8;
    localparam int unsigned MAX_IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWN      = 2'd1,
        TMO      = 2'd2,
        WAIT_REL = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic                 valid;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    // First requester strictly after `last` in circular order over n slots.
    function automatic rr_pick_t rr_pick(input logic [MAX_MASTERS-1:0] req,
                                         input logic [MAX_IDX_W-1:0]   last,
                                         input int unsigned            n);
        rr_pick_t    res;
        int unsigned idx;
        res = '0;
        for (int unsigned k = 1; k <= MAX_MASTERS; k++) begin
            idx = (32'(last) + k) % n;
            if (k <= n && !res.valid && req[idx[MAX_IDX_W-1:0]]) begin
                res.valid = 1'b1;
                res.idx   = idx[MAX_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_rr_arb_pick.sv
// Combinational round-robin picker: winner is the first requester after the last owner.
module wb_rr_arb_pick
    import wb_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] win,
    output logic          valid
);

    rr_pick_t pick;

    always_comb begin
        pick = rr_pick(MAX_MASTERS'(req), MAX_IDX_W'(last), N);
    end

    assign valid = pick.valid;
    assign win   = IW'(pick.idx);

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter granting one downstream port per bus tenure.
// Define WB_RR_ARBITER_TIMEOUT_EN to build in the stalled-strobe watchdog.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS      = 4,
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [N_MASTERS-1:0]                   m_cyc,
    input  logic [N_MASTERS-1:0]                   m_stb,
    input  logic [N_MASTERS-1:0]                   m_we,
    input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]     m_adr,
    input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]     m_dat_w,
    input  logic [N_MASTERS*(WB_DATA_WIDTH/8)-1:0] m_sel,
    output logic [WB_DATA_WIDTH-1:0]               m_dat_r,
    output logic [N_MASTERS-1:0]                   m_ack,
    output logic [N_MASTERS-1:0]                   m_err,
    output logic                                   s_cyc,
    output logic                                   s_stb,
    output logic                                   s_we,
    output logic [WB_ADDR_WIDTH-1:0]               s_adr,
    output logic [WB_DATA_WIDTH-1:0]               s_dat_w,
    output logic [WB_DATA_WIDTH/8-1:0]             s_sel,
    input  logic [WB_DATA_WIDTH-1:0]               s_dat_r,
    input  logic                                   s_ack,
    input  logic                                   s_err,
    output logic [N_MASTERS-1:0]                   gnt,
    output logic                                   busy
);

    localparam int unsigned IW = idx_width(N_MASTERS);
    localparam int unsigned SW = WB_DATA_WIDTH / 8;

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [IW-1:0]       last_q, last_d;
    logic [IW-1:0]       pick_win;
    logic                pick_valid;
    logic [N_MASTERS-1:0] gnt_d;

`ifdef WB_RR_ARBITER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

    wb_rr_arb_pick #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_pick (
        .req   (m_cyc),
        .last  (last_q),
        .win   (pick_win),
        .valid (pick_valid)
    );

    // Downstream passthrough from the owner; everything isolated outside OWN.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        m_ack   = '0;
        m_err   = '0;
        if (state_q == OWN) begin
            s_cyc          = m_cyc[owner_q];
            s_stb          = m_stb[owner_q];
            s_we           = m_we[owner_q];
            s_adr          = m_adr[32'(owner_q)*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
            s_dat_w        = m_dat_w[32'(owner_q)*WB_DATA_WIDTH +: WB_DATA_WIDTH];
            s_sel          = m_sel[32'(owner_q)*SW +: SW];
            m_ack[owner_q] = s_ack;
            m_err[owner_q] = s_err;
        end
`ifdef WB_RR_ARBITER_TIMEOUT_EN
        if (state_q == TMO) begin
            m_err[owner_q] = 1'b1;
        end
`endif
    end

    assign m_dat_r = s_dat_r;

    // Next-state: tenure ends when the owner drops CYC, with a one-cycle IDLE bubble.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt_d   = '0;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
        cnt_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_win;
                    last_d  = pick_win;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (!m_cyc[owner_q]) begin
                    state_d = IDLE;
                end
`ifdef WB_RR_ARBITER_TIMEOUT_EN
                else if (s_stb && !s_ack && !s_err) begin
                    if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        state_d = TMO;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`endif
            end
`ifdef WB_RR_ARBITER_TIMEOUT_EN
            TMO: begin
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (!m_cyc[owner_q]) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d != IDLE) begin
            gnt_d[owner_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(N_MASTERS - 1);
            gnt     <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt     <= gnt_d;
            busy    <= (state_d != IDLE);
        end
    end

`ifdef WB_RR_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule
